// File: rtl/mmio_out_bank.sv
// mmio_out_bank: memory-mapped output register bank for LED/HEX/LCD-class peripherals.
//
// Stores qualified by the MEM stage are decoded into a {channel, byte mask, data} write.
// The write goes into a posted-write FIFO that retires one entry per cycle into NUM_CH
// 32-bit channel registers. Malformed stores are dropped and raise a sticky error flag.
//
// Optional feature: define OUTBANK_BYPASS_EN to let a legal store that finds the FIFO empty
// write its channel directly at the accept edge instead of queueing.
//
// Ports:
//   i_clk, i_reset   clock (rising edge), synchronous active-high reset
//   i_wr_valid       qualified store request
//   o_wr_ready       FIFO not full (depends on occupancy only)
//   i_io_addr        store byte address; channel = addr[CH_SEL_LSB +: $clog2(NUM_CH)]
//   i_funct3         000 SB, 001 SH, 010 SW; anything else is illegal
//   i_st_data        LSB-aligned store data
//   i_rd_ch          readback channel select
//   o_rd_data        committed value of channel i_rd_ch (combinational)
//   o_ch_data        all committed channels, channel c at [c*32 +: 32]
//   o_busy           writes pending in the FIFO
//   o_err            sticky illegal-access flag
//   i_err_clr        clears o_err (a same-cycle new error wins)
module mmio_out_bank #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CH_SEL_LSB = 12,
  parameter logic [15:0] HEX_MASK   = 16'h000C
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_wr_valid,
  output logic                      o_wr_ready,
  input  logic [31:0]               i_io_addr,
  input  logic [2:0]                i_funct3,
  input  logic [31:0]               i_st_data,
  input  logic [$clog2(NUM_CH)-1:0] i_rd_ch,
  output logic [31:0]               o_rd_data,
  output logic [NUM_CH*32-1:0]      o_ch_data,
  output logic                      o_busy,
  output logic                      o_err,
  input  logic                      i_err_clr
);

  localparam int unsigned CW = $clog2(NUM_CH);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = PW + 1;
  localparam logic [NW-1:0] FULL = NW'(FIFO_DEPTH);

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [31:0]   mask;
    logic [31:0]   data;
  } entry_t;

  logic [31:0]   ch_q [NUM_CH];
  entry_t        fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [NW-1:0] count_q;
  logic          err_q;

  logic [CW-1:0] dec_ch;
  logic [1:0]    dec_off;
  logic [31:0]   dec_mask, dec_data;
  logic          dec_illegal;
  logic          accept, legal_acc, bypass, push, pop;
  entry_t        head;

  // Store decode: byte lanes come from the low address bits, channel from the select field.
  always_comb begin
    dec_ch      = i_io_addr[CH_SEL_LSB +: CW];
    dec_off     = i_io_addr[1:0];
    dec_mask    = '0;
    dec_data    = '0;
    dec_illegal = 1'b0;
    case (i_funct3)
      3'b000: begin
        dec_mask = 32'h0000_00FF << {dec_off, 3'b000};
        dec_data = {24'b0, i_st_data[7:0]} << {dec_off, 3'b000};
      end
      3'b001: begin
        dec_mask    = 32'h0000_FFFF << {dec_off[1], 4'b0000};
        dec_data    = {16'b0, i_st_data[15:0]} << {dec_off[1], 4'b0000};
        dec_illegal = dec_off[0];
      end
      3'b010: begin
        dec_mask    = 32'hFFFF_FFFF;
        dec_data    = i_st_data;
        dec_illegal = (dec_off != 2'b00);
      end
      default: dec_illegal = 1'b1;
    endcase
    // Only reachable when NUM_CH is not a power of two.
    if (32'(dec_ch) >= NUM_CH) dec_illegal = 1'b1;
  end

  always_comb begin
    head       = fifo_q[rd_ptr_q];
    o_wr_ready = (count_q != FULL);
    accept     = i_wr_valid && o_wr_ready;
    legal_acc  = accept && !dec_illegal;
    pop        = (count_q != '0);
`ifdef OUTBANK_BYPASS_EN
    // Only when nothing is queued, so program order cannot be violated.
    bypass     = legal_acc && (count_q == '0);
`else
    bypass     = 1'b0;
`endif
    push       = legal_acc && !bypass;
  end

  // FIFO storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge i_clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{ch: dec_ch, mask: dec_mask, data: dec_data};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        ch_q[c] <= HEX_MASK[c] ? 32'h7F7F_7F7F : 32'h0000_0000;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // pop and bypass are mutually exclusive (bypass needs an empty FIFO).
      if (pop) begin
        ch_q[head.ch] <= (ch_q[head.ch] & ~head.mask) | (head.data & head.mask);
        rd_ptr_q      <= rd_ptr_q + 1'b1;
      end
      if (bypass) begin
        ch_q[dec_ch] <= (ch_q[dec_ch] & ~dec_mask) | (dec_data & dec_mask);
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (accept && dec_illegal) begin
        err_q <= 1'b1;
      end else if (i_err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (32'(i_rd_ch) < NUM_CH) o_rd_data = ch_q[i_rd_ch];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch_out
    assign o_ch_data[c*32 +: 32] = ch_q[c];
  end

  assign o_busy = (count_q != '0);
  assign o_err  = err_q;

endmodule

// File: tb/tb_mmio_out_bank.sv
// Self-checking bench for mmio_out_bank: directed scenarios followed by random stores,
// all compared every cycle against a queue-based reference model.
module tb_mmio_out_bank;

  localparam int NUM_CH     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CH_SEL_LSB = 12;
  localparam int CW         = $clog2(NUM_CH);

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  logic                   clk = 1'b0;
  logic                   reset, wr_valid, wr_ready, err_clr, busy, err;
  logic [31:0]            io_addr, st_data, rd_data;
  logic [2:0]             funct3;
  logic [CW-1:0]          rd_ch;
  logic [NUM_CH*32-1:0]   ch_data;

  always #5 clk = ~clk;

  mmio_out_bank #(
    .NUM_CH    (NUM_CH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CH_SEL_LSB(CH_SEL_LSB),
    .HEX_MASK  (16'h000C)
  ) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_wr_valid(wr_valid),
    .o_wr_ready(wr_ready),
    .i_io_addr (io_addr),
    .i_funct3  (funct3),
    .i_st_data (st_data),
    .i_rd_ch   (rd_ch),
    .o_rd_data (rd_data),
    .o_ch_data (ch_data),
    .o_busy    (busy),
    .o_err     (err),
    .i_err_clr (err_clr)
  );

  // Reference model: channel values, a queue of pending writes, the error flag.
  typedef struct {
    int          ch;
    logic [31:0] mask;
    logic [31:0] data;
  } wr_t;

  logic [31:0] m_ch [NUM_CH];
  wr_t         m_q[$];
  logic        m_err;
  logic [15:0] hex_mask = 16'h000C;

  int errors = 0;
  int checks = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) m_ch[c] = hex_mask[c] ? 32'h7F7F7F7F : 32'h0;
    m_q.delete();
    m_err = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < NUM_CH; c++) begin
      check32($sformatf("%s ch%0d", tag, c), ch_data[c*32 +: 32], m_ch[c]);
    end
    check32({tag, " busy"}, 32'(busy), 32'(m_q.size() != 0));
    check32({tag, " err"}, 32'(err), 32'(m_err));
    check32({tag, " rd_data"}, rd_data, m_ch[rd_ch]);
  endtask

  // One clock: drive inputs, check combinational outputs, predict the edge, check after it.
  task automatic step(input logic v, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] d, input logic clr, input logic rst, input string tag);
    int          pre_size, ch, off;
    logic        rdy, acc, ill;
    logic [31:0] mask, data;
    wr_valid = v; io_addr = a; funct3 = f3; st_data = d; err_clr = clr; reset = rst;
    rd_ch = CW'($urandom_range(NUM_CH - 1));
    #1;
    pre_size = m_q.size();
    rdy      = pre_size < FIFO_DEPTH;
    check32({tag, " wr_ready"}, 32'(wr_ready), 32'(rdy));
    check32({tag, " rd_data_pre"}, rd_data, m_ch[rd_ch]);
    acc = v && rdy;

    ch   = int'((a >> CH_SEL_LSB) % (1 << CW));
    off  = int'(a % 4);
    mask = 0; data = 0; ill = 0;
    case (f3)
      SB: begin mask = 32'hFF << (8 * off); data = (d & 32'hFF) << (8 * off); end
      SH: begin ill = (off % 2) != 0; mask = 32'hFFFF << (8 * off); data = (d & 32'hFFFF) << (8 * off); end
      SW: begin ill = off != 0; mask = 32'hFFFFFFFF; data = d; end
      default: ill = 1;
    endcase
    if (ch >= NUM_CH) ill = 1;

    if (rst) begin
      model_reset();
    end else begin
      if (pre_size != 0) begin
        wr_t h = m_q.pop_front();
        m_ch[h.ch] = (m_ch[h.ch] & ~h.mask) | (h.data & h.mask);
      end
      if (acc && !ill) begin
`ifdef OUTBANK_BYPASS_EN
        if (pre_size == 0) m_ch[ch] = (m_ch[ch] & ~mask) | (data & mask);
        else m_q.push_back('{ch: ch, mask: mask, data: data});
`else
        m_q.push_back('{ch: ch, mask: mask, data: data});
`endif
      end
      if (acc && ill) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, SW, 32'h0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    logic [31:0] exp4;
    wr_valid = 0; io_addr = 0; funct3 = 0; st_data = 0; err_clr = 0; rd_ch = 0; reset = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();

    // 1: reset values
    check_all("reset");
    check32("reset ch2 hex", ch_data[2*32 +: 32], 32'h7F7F7F7F);
    check32("reset ch0 zero", ch_data[0 +: 32], 32'h0);
    check32("reset wr_ready", 32'(wr_ready), 32'd1);
    step(1'b0, 32'h0, SW, 32'h0, 1'b0, 1'b1, "reset_step");

    // 2: SW then SB back-to-back into channel 1
    step(1'b1, 32'h1000, SW, 32'h12345678, 1'b0, 1'b0, "t2_sw");
    step(1'b1, 32'h1002, SB, 32'h000000AB, 1'b0, 1'b0, "t2_sb");
    idle(2, "t2_drain");
    check32("t2 ch1 final", ch_data[1*32 +: 32], 32'h12AB5678);

    // 3: six back-to-back SWs to channel 0
    for (int i = 1; i <= 6; i++) step(1'b1, 32'h0, SW, 32'(i), 1'b0, 1'b0, "t3_burst");
    idle(FIFO_DEPTH + 1, "t3_drain");
    check32("t3 ch0 final", ch_data[0 +: 32], 32'd6);

    // 4: illegal stores and error flag
    step(1'b1, 32'h2001, SH, 32'hFFFF, 1'b0, 1'b0, "t4_sh_misaligned");
    step(1'b1, 32'h0000, 3'b011, 32'h1, 1'b0, 1'b0, "t4_bad_funct3");
    idle(2, "t4_idle");
    check32("t4 err set", 32'(err), 32'd1);
    step(1'b0, 32'h0, SW, 32'h0, 1'b1, 1'b0, "t4_clr");
    check32("t4 err cleared", 32'(err), 32'd0);
    step(1'b1, 32'h0003, SW, 32'h5, 1'b1, 1'b0, "t4_clr_vs_set");
    check32("t4 set wins", 32'(err), 32'd1);
    step(1'b0, 32'h0, SW, 32'h0, 1'b1, 1'b0, "t4_clr2");

    // 5: writes in flight, then reset discards them
    step(1'b1, 32'h5000, SW, 32'hAAAA5555, 1'b0, 1'b0, "t5_w0");
    step(1'b1, 32'h6000, SW, 32'h11112222, 1'b0, 1'b0, "t5_w1");
    step(1'b1, 32'h7000, SW, 32'h33334444, 1'b0, 1'b0, "t5_w2");
    step(1'b0, 32'h0, SW, 32'h0, 1'b0, 1'b1, "t5_reset");
    check32("t5 busy", 32'(busy), 32'd0);
    check32("t5 ch7 reset", ch_data[7*32 +: 32], 32'h0);
    check32("t5 ch3 reset", ch_data[3*32 +: 32], 32'h7F7F7F7F);
    idle(3, "t5_idle");

    // 6: SW into empty FIFO, latency depends on bypass
    step(1'b1, 32'h4000, SW, 32'hDEADBEEF, 1'b0, 1'b0, "t6_sw");
`ifdef OUTBANK_BYPASS_EN
    exp4 = 32'hDEADBEEF;
`else
    exp4 = 32'h0;
`endif
    check32("t6 ch4 after accept", ch_data[4*32 +: 32], exp4);
    idle(1, "t6_idle");
    check32("t6 ch4 final", ch_data[4*32 +: 32], 32'hDEADBEEF);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int          r, chs;
      logic [31:0] a;
      logic [2:0]  f3;
      r   = $urandom_range(11);
      f3  = (r < 9) ? 3'(r % 3) : 3'($urandom_range(7, 3));
      chs = $urandom_range(NUM_CH - 1);
      a   = (32'(chs) << CH_SEL_LSB) | 32'($urandom_range(3));
      if ($urandom_range(7) == 0) a = a | ($urandom & 32'hFFFF8000);
      step($urandom_range(3) != 0, a, f3, $urandom, $urandom_range(15) == 0,
           $urandom_range(63) == 0, "rand");
    end
    idle(FIFO_DEPTH + 1, "final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
